cpu_oci_trace_capture: RTL and testbench

- Parametrised successor to the OCI test-bench monitor. It captures completed DCT trace packets (dct_buffer plus dct_count) into an internal FIFO, and a bench or debug reader drains the FIFO over a valid/ready port.
- It sequences end-of-test handling from test_ending and test_has_ended: flushing a partial packet, draining, then signalling done.
- It sits beside the OCI block in simulation and debug builds.

---
 rtl/cpu_oci_trace_pkg.sv | 24 ++
 rtl/cpu_oci_trace_fifo.sv | 72 +++++++
 rtl/cpu_oci_trace_capture.sv | 121 ++++++++++++
 tb/tb_cpu_oci_trace_capture.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_oci_trace_pkg.sv
// rtl/cpu_oci_trace_pkg.sv - shared types, widths and helpers for OCI trace capture
//
// Purpose: common definitions imported by the trace capture top and its FIFO.
//   trace_state_e : end-of-test sequencing states (RUN, FLUSH, DRAIN, DONE)
//   DEF_DATA_W    : default dct_buffer width
//   DEF_CNT_W     : default dct_count width
//   entry_width() : width of one FIFO entry {count, buffer}
package cpu_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam int DEF_DATA_W = 30;
  localparam int DEF_CNT_W  = 4;

  function automatic int entry_width(input int data_w, input int cnt_w);
    return data_w + cnt_w;
  endfunction

endpackage

// File: rtl/cpu_oci_trace_fifo.sv
// rtl/cpu_oci_trace_fifo.sv - parametrised synchronous FIFO for trace packets
//
// Purpose: stores captured trace entries; head data is presented from the
// storage array and reads as zero while empty.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   push_i        : write request; taken when not full, or when full with a pop
//   push_data_i   : entry to write
//   pop_i         : read request; taken only when not empty
//   head_o        : head entry (zero when empty)
//   full_o        : level == DEPTH
//   empty_o       : level == 0
//   level_o       : occupancy 0..DEPTH
module cpu_oci_trace_fifo #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_en, rd_en;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign rd_en = pop_i && !empty_o;
  // When full, the slot being popped is the one written, so push+pop is safe.
  assign wr_en = push_i && (!full_o || rd_en);

  always_comb begin
    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/cpu_oci_trace_capture.sv
// rtl/cpu_oci_trace_capture.sv - captures completed DCT trace packets into a drainable FIFO
//
// Purpose: detects packet completion (count falling to zero), pushes
// {count, buffer} into a FIFO, tracks drops/captures and sequences
// end-of-test flushing and draining.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   dct_buffer      : packed trace entries from OCI
//   dct_count       : number of valid entries in dct_buffer
//   test_ending     : end-of-test requested (level)
//   test_has_ended  : test finished (level)
//   rd_ready        : reader accepts rd_data this cycle
//   rd_valid        : FIFO non-empty
//   rd_data         : head entry {count, buffer}
//   level           : FIFO occupancy
//   overflow        : sticky drop flag
//   drop_count      : saturating dropped-packet count
//   capture_count   : wrapping accepted-packet count
//   flushing        : high in FLUSH and DRAIN
//   done            : high in DONE
module cpu_oci_trace_capture
  import cpu_oci_trace_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int CNT_W   = DEF_CNT_W,
  parameter  int DEPTH   = 16,
  parameter  int DROP_W  = 16,
  localparam int ENTRY_W = entry_width(DATA_W, CNT_W),
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  dct_buffer,
  input  logic [CNT_W-1:0]   dct_count,
  input  logic               test_ending,
  input  logic               test_has_ended,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [LW-1:0]      level,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_count,
  output logic [31:0]        capture_count,
  output logic               flushing,
  output logic               done
);

  trace_state_e      state_q, state_d;
  logic [DATA_W-1:0] prev_buf_q;
  logic [CNT_W-1:0]  prev_cnt_q;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic [31:0]       cap_cnt_q;

  logic pkt_evt, flush_push, push;
  logic fifo_full, fifo_empty;
  logic accepted, dropped;

  // A packet completes when the count falls from non-zero to zero.
  assign pkt_evt    = (state_q == ST_RUN) && (prev_cnt_q != '0) && (dct_count == '0);
  // FLUSH salvages whatever partial packet was in flight.
  assign flush_push = (state_q == ST_FLUSH) && (prev_cnt_q != '0);
  assign push       = pkt_evt || flush_push;

  // A full FIFO is never empty, so rd_ready alone means a pop happens.
  assign accepted = push && (!fifo_full || rd_ready);
  assign dropped  = push && fifo_full && !rd_ready;

  cpu_oci_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({prev_cnt_q, prev_buf_q}),
    .pop_i       (rd_ready),
    .head_o      (rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (test_ending || test_has_ended) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && test_has_ended) state_d = ST_DONE;
      default:  state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      prev_buf_q <= '0;
      prev_cnt_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      cap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_buf_q <= dct_buffer;
      prev_cnt_q <= dct_count;
      if (accepted) cap_cnt_q <= cap_cnt_q + 32'd1;
      if (dropped) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
      end
    end
  end

  assign rd_valid      = !fifo_empty;
  assign overflow      = overflow_q;
  assign drop_count    = drop_cnt_q;
  assign capture_count = cap_cnt_q;
  assign flushing      = (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_cpu_oci_trace_capture.sv
// tb/tb_cpu_oci_trace_capture.sv - self-checking bench for cpu_oci_trace_capture
module tb_cpu_oci_trace_capture;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic        rd_ready;
  logic        rd_valid;
  logic [33:0] rd_data;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  logic [31:0] capture_count;
  logic        flushing;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_oci_trace_capture #(
    .DATA_W (30),
    .CNT_W  (4),
    .DEPTH  (DEPTH),
    .DROP_W (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .level          (level),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .capture_count  (capture_count),
    .flushing       (flushing),
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [29:0] b, input logic [3:0] c,
                        input logic te, input logic the, input logic rr);
    dct_buffer     = b;
    dct_count      = c;
    test_ending    = te;
    test_has_ended = the;
    rd_ready       = rr;
  endtask

  task automatic do_reset();
    set_in(30'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_RUN, M_FLUSH, M_DRAIN, M_DONE} mphase_e;
  mphase_e     m_phase;
  logic [33:0] m_q[$];
  logic [29:0] m_prev_buf;
  logic [3:0]  m_prev_cnt;
  logic        m_ovf;
  logic [15:0] m_drop;
  logic [31:0] m_cap;

  function automatic void model_reset();
    m_phase    = M_RUN;
    m_q.delete();
    m_prev_buf = '0;
    m_prev_cnt = '0;
    m_ovf      = 1'b0;
    m_drop     = '0;
    m_cap      = '0;
  endfunction

  function automatic void model_tick();
    int          sz;
    bit          pop;
    bit          push;
    logic [33:0] d;
    sz   = m_q.size();
    pop  = (sz != 0) && rd_ready;
    push = 1'b0;
    d    = {m_prev_cnt, m_prev_buf};
    if (m_phase == M_RUN && m_prev_cnt != 0 && dct_count == 0) push = 1'b1;
    if (m_phase == M_FLUSH && m_prev_cnt != 0) push = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) begin
        m_q.push_back(d);
        m_cap = m_cap + 32'd1;
      end else begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    case (m_phase)
      M_RUN:   if (test_ending || test_has_ended) m_phase = M_FLUSH;
      M_FLUSH: m_phase = M_DRAIN;
      M_DRAIN: if (sz == 0 && test_has_ended) m_phase = M_DONE;
      default: m_phase = M_DONE;
    endcase
    m_prev_buf = dct_buffer;
    m_prev_cnt = dct_count;
  endfunction

  task automatic compare_model();
    logic [33:0] hd;
    hd = (m_q.size() != 0) ? m_q[0] : 34'd0;
    check("rnd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
    check("rnd_data", 64'(rd_data), 64'(hd));
    check("rnd_level", 64'(level), 64'(m_q.size()));
    check("rnd_overflow", 64'(overflow), 64'(m_ovf));
    check("rnd_drop", 64'(drop_count), 64'(m_drop));
    check("rnd_cap", 64'(capture_count), 64'(m_cap));
    check("rnd_flushing", 64'(flushing), 64'(m_phase == M_FLUSH || m_phase == M_DRAIN));
    check("rnd_done", 64'(done), 64'(m_phase == M_DONE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [29:0] bufv;
    logic [3:0]  cnt;
    logic        rr;
    logic        exp_valid;
    logic [33:0] exp_data;
    logic [4:0]  exp_level;
    logic [31:0] exp_cap;
  } vec_t;

  vec_t        vecs[8];
  logic [33:0] exp_pkt[18];
  logic [33:0] late_pkt;

  initial begin
    reset = 1'b1;
    set_in(30'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    vecs[0] = '{30'h2AAAAAAA, 4'd3, 1'b0, 1'b0, 34'd0, 5'd0, 32'd0};
    vecs[1] = '{30'h2AAAAAAA, 4'd0, 1'b0, 1'b1, {4'h3, 30'h2AAAAAAA}, 5'd1, 32'd1};
    vecs[2] = '{30'h15555555, 4'd7, 1'b0, 1'b1, {4'h3, 30'h2AAAAAAA}, 5'd1, 32'd1};
    vecs[3] = '{30'h15555555, 4'd0, 1'b0, 1'b1, {4'h3, 30'h2AAAAAAA}, 5'd2, 32'd2};
    vecs[4] = '{30'h15555555, 4'd0, 1'b1, 1'b1, {4'h7, 30'h15555555}, 5'd1, 32'd2};
    vecs[5] = '{30'h00000001, 4'd1, 1'b1, 1'b0, 34'd0, 5'd0, 32'd2};
    vecs[6] = '{30'h00000001, 4'd0, 1'b1, 1'b1, {4'h1, 30'h00000001}, 5'd1, 32'd3};
    vecs[7] = '{30'h00000001, 4'd0, 1'b0, 1'b1, {4'h1, 30'h00000001}, 5'd1, 32'd3};

    // Reset state
    do_reset();
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_cap", 64'(capture_count), 64'd0);
    check("rst_flushing", 64'(flushing), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // Basic capture / stability / pop via table
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].bufv, vecs[i].cnt, 1'b0, 1'b0, vecs[i].rr);
      step();
      check($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i), 64'(rd_data), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].exp_level));
      check($sformatf("vec%0d_cap", i), 64'(capture_count), 64'(vecs[i].exp_cap));
    end

    // Backpressure and overflow: 18 packets into 16 entries
    do_reset();
    for (int i = 0; i < 18; i++) begin
      logic [29:0] b;
      logic [3:0]  c;
      b = 30'(i * 977 + 5);
      c = 4'((i % 15) + 1);
      exp_pkt[i] = {c, b};
      set_in(b, c, 1'b0, 1'b0, 1'b0);
      step();
      set_in(b, 4'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    check("ovf_level", 64'(level), 64'd16);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drop", 64'(drop_count), 64'd2);
    check("ovf_cap", 64'(capture_count), 64'd16);
    check("ovf_head", 64'(rd_data), 64'(exp_pkt[0]));

    // Full with simultaneous pop on the packet event
    set_in(30'h3000ABCD, 4'd9, 1'b0, 1'b0, 1'b0);
    step();
    late_pkt = {4'd9, 30'h3000ABCD};
    set_in(30'h3000ABCD, 4'd0, 1'b0, 1'b0, 1'b1);
    step();
    check("fullpop_level", 64'(level), 64'd16);
    check("fullpop_drop", 64'(drop_count), 64'd2);
    check("fullpop_cap", 64'(capture_count), 64'd17);
    for (int k = 0; k < 16; k++) begin
      logic [33:0] e;
      e = (k < 15) ? exp_pkt[k + 1] : late_pkt;
      check($sformatf("drain%0d_valid", k), 64'(rd_valid), 64'd1);
      check($sformatf("drain%0d_data", k), 64'(rd_data), 64'(e));
      step();
    end
    check("drained_level", 64'(level), 64'd0);
    check("drained_valid", 64'(rd_valid), 64'd0);

    // Flush of a partial packet
    do_reset();
    set_in(30'h0ABCDEF1, 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    set_in(30'h0ABCDEF1, 4'd5, 1'b1, 1'b0, 1'b0);
    step();
    check("flush_flushing", 64'(flushing), 64'd1);
    check("flush_level0", 64'(level), 64'd0);
    set_in(30'h0ABCDEF1, 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    check("flush_level1", 64'(level), 64'd1);
    check("flush_data", 64'(rd_data), 64'({4'd5, 30'h0ABCDEF1}));
    check("flush_cap", 64'(capture_count), 64'd1);
    set_in(30'h0ABCDEF1, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("flush_nopush_level", 64'(level), 64'd1);
    check("flush_stay", 64'(flushing), 64'd1);
    set_in(30'h00000077, 4'd4, 1'b0, 1'b0, 1'b0);
    step();
    set_in(30'h00000077, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("flush_nopush2_level", 64'(level), 64'd1);
    check("flush_nopush2_cap", 64'(capture_count), 64'd1);

    // End of test: three entries drained, then done
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(30'(i + 40), 4'(i + 2), 1'b0, 1'b0, 1'b0);
      step();
      set_in(30'(i + 40), 4'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    check("eot_level3", 64'(level), 64'd3);
    set_in(30'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    step();
    check("eot_l2", 64'(level), 64'd2);
    check("eot_flush", 64'(flushing), 64'd1);
    step();
    check("eot_l1", 64'(level), 64'd1);
    check("eot_notdone1", 64'(done), 64'd0);
    step();
    check("eot_l0", 64'(level), 64'd0);
    check("eot_notdone0", 64'(done), 64'd0);
    step();
    check("eot_done", 64'(done), 64'd1);
    check("eot_done_valid", 64'(rd_valid), 64'd0);
    check("eot_done_flushing", 64'(flushing), 64'd0);
    set_in(30'd9, 4'd3, 1'b0, 1'b1, 1'b1);
    step();
    set_in(30'd9, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("eot_done_hold", 64'(done), 64'd1);
    check("eot_done_hold_valid", 64'(rd_valid), 64'd0);

    // Asynchronous reset in DRAIN with data present
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(30'(i + 200), 4'd2, 1'b0, 1'b0, 1'b0);
      step();
      set_in(30'(i + 200), 4'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    set_in(30'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    set_in(30'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("ares_pre_level", 64'(level), 64'd4);
    check("ares_pre_flushing", 64'(flushing), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ares_level", 64'(level), 64'd0);
    check("ares_valid", 64'(rd_valid), 64'd0);
    check("ares_overflow", 64'(overflow), 64'd0);
    check("ares_cap", 64'(capture_count), 64'd0);
    check("ares_flushing", 64'(flushing), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    set_in(30'h01234567, 4'd6, 1'b0, 1'b0, 1'b0);
    step();
    set_in(30'h01234567, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("ares_new_valid", 64'(rd_valid), 64'd1);
    check("ares_new_data", 64'(rd_data), 64'({4'd6, 30'h01234567}));
    check("ares_new_cap", 64'(capture_count), 64'd1);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 600 == 599) begin
        do_reset();
        model_reset();
        compare_model();
      end else begin
        logic [3:0] c;
        logic       te, the, rr;
        c   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        rr  = ($urandom_range(0, 3) == 0);
        te  = ($urandom_range(0, 299) == 0);
        the = (m_phase == M_RUN) ? ($urandom_range(0, 299) == 0)
                                 : ($urandom_range(0, 3) == 0);
        if (m_phase != M_RUN) rr = ($urandom_range(0, 1) == 0);
        set_in(30'($urandom), c, te, the, rr);
        model_tick();
        step();
        compare_model();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
